// File: rtl/spi_controller_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//
// Shared definitions for the SPI initiator and the on-chip SPI peripheral
// register block it talks to.
//   - Frame geometry: {rw, addr[6:0], wdata[7:0]}, sent MSB first.
//   - Controller state encoding.
//   - Peripheral register map. The peripheral silently discards any address
//     above MAX_ADDRESS, so the controller does not range-check addresses.
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    localparam logic [ADDR_W-1:0] MAX_ADDRESS = 7'h04;
    localparam logic              RW_WRITE    = 1'b1;

    // Peripheral register map
    localparam logic [ADDR_W-1:0] REG_CTRL    = 7'h00;
    localparam logic [ADDR_W-1:0] REG_STATUS  = 7'h01;
    localparam logic [ADDR_W-1:0] REG_PWM     = 7'h02;
    localparam logic [ADDR_W-1:0] REG_SCRATCH = 7'h03;
    localparam logic [ADDR_W-1:0] REG_ID      = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } ctrl_state_t;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return {rw, addr, wdata};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div
//
// Half-period counter for the SPI clock. It counts clk cycles while enabled
// and pulses phase_tick on the cycle in which the count reaches CLK_DIV-1.
// The count reloads to zero on that same edge, so every sclk phase lasts
// exactly CLK_DIV cycles.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   count while high; held at zero while low
//   restart    in   force the count back to zero
//   phase_tick out  one-cycle pulse at the end of each half-period
// ---------------------------------------------------------------------------
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic phase_tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] count;

    assign phase_tick = enable && (count == LAST);

    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable || restart || phase_tick) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
//
// SPI mode-0 initiator. A single-cycle start in IDLE captures one 16-bit
// frame {rw, addr, wdata} and sends it MSB first on copi. copi changes on
// sclk falling edges, so it is stable for a full half-period around every
// rising edge. Sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
// All outputs come straight from registers.
//
// Build option: define SPI_CTRL_READBACK_EN to add cipo/rdata. cipo is
// sampled on the clk edge where sclk rises for frame bits 7..0, and the
// captured byte appears on rdata in the done cycle.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request pulse, accepted only in IDLE
//   rw     in   frame bit 15 (1 = write)
//   addr   in   frame bits 14:8
//   wdata  in   frame bits 7:0
//   busy   out  high from the cycle after acceptance until done
//   done   out  one-cycle pulse at end of frame
//   sclk   out  SPI clock, idle low
//   ncs    out  chip select, active low
//   copi   out  serial data to peripheral
//   cipo   in   serial data from peripheral   (SPI_CTRL_READBACK_EN only)
//   rdata  out  captured read byte            (SPI_CTRL_READBACK_EN only)
// ---------------------------------------------------------------------------
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              ncs,
    output logic              copi
`ifdef SPI_CTRL_READBACK_EN
    ,
    input  logic              cipo,
    output logic [DATA_W-1:0] rdata
`endif
);

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    // GAP is entered on the edge ncs rises; done is raised one cycle before
    // the gap ends so that its pulse occupies the final gap cycle.
    localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 2);
    localparam logic [4:0] LAST_BIT   = 5'(FRAME_BITS);

    ctrl_state_t           state, state_nxt;
    logic [FRAME_BITS-1:0] shift_reg, shift_nxt;
    logic [4:0]            bit_cnt, bit_nxt;     // sclk rising edges so far
    logic [7:0]            wait_cnt, wait_nxt;   // SETUP/HOLD/GAP cycle count
    logic                  busy_nxt, done_nxt, sclk_nxt, ncs_nxt, copi_nxt;
    logic                  phase_tick, div_restart;

    assign div_restart = (state == SETUP) && (wait_cnt == SETUP_LAST);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (state == SHIFT),
        .restart    (div_restart),
        .phase_tick (phase_tick)
    );

`ifdef SPI_CTRL_READBACK_EN
    logic sample_en;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            ncs       <= 1'b1;
            copi      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_nxt;
            wait_cnt  <= wait_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            sclk      <= sclk_nxt;
            ncs       <= ncs_nxt;
            copi      <= copi_nxt;
        end
    end

    // NOTE: every signal written here is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        bit_nxt   = bit_cnt;
        wait_nxt  = '0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        sclk_nxt  = sclk;
        ncs_nxt   = ncs;
        copi_nxt  = copi;
`ifdef SPI_CTRL_READBACK_EN
        sample_en = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the
                // frame just finished and is dropped.
                if (start && !done) begin
                    shift_nxt = pack_frame(rw, addr, wdata);
                    copi_nxt  = rw;
                    ncs_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                    sclk_nxt  = 1'b0;
                    bit_nxt   = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (div_restart) begin
                    sclk_nxt  = 1'b1;
                    bit_nxt   = 5'd1;
                    state_nxt = SHIFT;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            SHIFT: begin
                if (phase_tick) begin
                    if (sclk) begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = HOLD;
                        end else begin
                            shift_nxt = {shift_reg[FRAME_BITS-2:0], 1'b0};
                            copi_nxt  = shift_reg[FRAME_BITS-2];
                        end
                    end else begin
                        sclk_nxt = 1'b1;
                        bit_nxt  = bit_cnt + 5'd1;
`ifdef SPI_CTRL_READBACK_EN
                        // Rises 9..16 carry frame bits 7..0.
                        sample_en = (bit_cnt >= 5'd8);
`endif
                    end
                end
            end
            HOLD: begin
                if (wait_cnt == HOLD_LAST) begin
                    ncs_nxt   = 1'b1;
                    copi_nxt  = 1'b0;
                    state_nxt = GAP;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            GAP: begin
                if (wait_cnt == GAP_LAST) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SPI_CTRL_READBACK_EN
    logic [DATA_W-1:0] capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture <= '0;
            rdata   <= '0;
        end else begin
            if (sample_en) begin
                capture <= {capture[DATA_W-2:0], cipo};
            end
            if (done_nxt) begin
                rdata <= capture;
            end
        end
    end
`endif

endmodule
